// File: rtl/sdc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// sdc_pkg : shared SD data-path constants, FSM encoding, CRC helper
// Rev 1.0
// ----------------------------------------------------------------
package sdc_pkg;

  localparam logic [15:0] CRC16_POLY        = 16'h1021;
  localparam int unsigned SDC_WORDS_PER_BLK = 64;
  localparam int unsigned SDC_WORD_W        = 64;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_CHECK = 4'b1000
  } sdc_rd_state_e;

  // One serial CRC-16 step, data bit entering at the MSB end.
  function automatic logic [15:0] crc16_bit(input logic [15:0] crc,
                                            input logic        din,
                                            input logic [15:0] poly);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdc_crc16_ser2.sv
`default_nettype none
// ----------------------------------------------------------------
// sdc_crc16_ser2 : CRC-16 accumulator, 2 bits/cycle, MSB first
// Rev 1.0
// ----------------------------------------------------------------
module sdc_crc16_ser2
  import sdc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        en_i,
  input  logic [1:0]  bits_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d, step1;

  always_comb begin
    step1 = crc16_bit(crc_q, bits_i[1], POLY);
    crc_d = crc16_bit(step1, bits_i[0], POLY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= 16'h0000;
    end else if (clr_i) begin
      crc_q <= 16'h0000;
    end else if (load_i) begin
      crc_q <= load_val_i;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/sdc_rd_blk_wr_chk.sv
`default_nettype none
// ----------------------------------------------------------------
// sdc_rd_blk_wr_chk : writes read-block words to BRAM, checks CRC-16
// Rev 1.0
// ----------------------------------------------------------------
module sdc_rd_blk_wr_chk
  import sdc_pkg::*;
#(
  parameter int unsigned ADDR_W        = 9,
  parameter int unsigned WORDS_PER_BLK = SDC_WORDS_PER_BLK,
  parameter logic [15:0] CRC_POLY      = CRC16_POLY
) (
  input  logic                  sdc_clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     blk_base_addr,
  input  logic                  blk_abort,
  input  logic                  latch_wrd_strb,
  input  logic [SDC_WORD_W-1:0] dat_wrd,
  input  logic                  latch_crc_strb,
  input  logic [15:0]           crc_16,
  output logic                  bram_we,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [SDC_WORD_W-1:0] bram_din,
  output logic [6:0]            wrd_cnt,
  output logic                  blk_done,
  output logic                  crc_ok,
  output logic                  crc_err,
  output logic                  len_err,
  output logic                  ovr_err
);

  sdc_rd_state_e         state_q, state_d;
  logic [SDC_WORD_W-1:0] sh_q, sh_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [15:0]           crc_exp_q, crc_exp_d, exp_sel, crc_val;
  logic                  pend_q, pend_d;
  logic                  ok_q, ok_d, err_q, err_d, len_q, len_d, ovr_q, ovr_d;
  logic                  crc_clr, crc_en;

  logic [6:0]            wrd_cnt_q, cnt_base;
  logic [ADDR_W-1:0]     addr_q, base_sel;
  logic [SDC_WORD_W-1:0] din_q;
  logic                  we_q;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    base_d    = base_q;
    crc_exp_d = crc_exp_q;
    pend_d    = pend_q;
    ok_d      = ok_q;
    err_d     = err_q;
    len_d     = len_q;
    ovr_d     = ovr_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    exp_sel   = latch_crc_strb ? crc_16 : crc_exp_q;

    case (state_q)
      ST_IDLE: begin
        if (latch_wrd_strb) begin
          base_d    = blk_base_addr;
          crc_clr   = 1'b1;
          {ok_d, err_d, len_d, ovr_d} = 4'b0000;
          sh_d      = dat_wrd;
          bit_cnt_d = 5'd0;
          pend_d    = latch_crc_strb;
          if (latch_crc_strb) crc_exp_d = crc_16;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        crc_en    = 1'b1;
        sh_d      = {sh_q[SDC_WORD_W-3:0], 2'b00};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) state_d = ST_WAIT;
        // Overlapping word is still stored, but cannot enter the CRC.
        if (latch_wrd_strb) ovr_d = 1'b1;
        if (latch_crc_strb) begin
          crc_exp_d = crc_16;
          pend_d    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (latch_wrd_strb) begin
          sh_d      = dat_wrd;
          bit_cnt_d = 5'd0;
          state_d   = ST_SHIFT;
          if (latch_crc_strb) begin
            crc_exp_d = crc_16;
            pend_d    = 1'b1;
          end
        end else if (latch_crc_strb || pend_q) begin
          crc_exp_d = exp_sel;
          pend_d    = 1'b0;
          len_d     = (wrd_cnt_q != 7'(WORDS_PER_BLK));
          ok_d      = (crc_val == exp_sel) && !len_d && !ovr_q;
          err_d     = !ok_d;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (blk_abort) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
      crc_clr = 1'b1;
      crc_en  = 1'b0;
      {ok_d, err_d, len_d, ovr_d} = 4'b0000;
    end
  end

  always_ff @(posedge sdc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= 5'd0;
      base_q    <= '0;
      crc_exp_q <= 16'h0000;
      pend_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      base_q    <= base_d;
      crc_exp_q <= crc_exp_d;
      pend_q    <= pend_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      len_q     <= len_d;
      ovr_q     <= ovr_d;
    end
  end

  // The first word of a block uses the live base and a zero count.
  assign base_sel = (state_q == ST_IDLE) ? blk_base_addr : base_q;
  assign cnt_base = (state_q == ST_IDLE) ? 7'd0 : wrd_cnt_q;

  always_ff @(posedge sdc_clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      wrd_cnt_q <= 7'd0;
    end else if (blk_abort) begin
      we_q      <= 1'b0;
      wrd_cnt_q <= 7'd0;
    end else begin
      we_q <= latch_wrd_strb;
      if (latch_wrd_strb) begin
        din_q     <= dat_wrd;
        addr_q    <= base_sel + ADDR_W'(cnt_base);
        wrd_cnt_q <= (cnt_base == 7'h7F) ? 7'h7F : cnt_base + 7'd1;
      end
    end
  end

  sdc_crc16_ser2 #(
    .POLY(CRC_POLY)
  ) u_crc (
    .clk_i      (sdc_clk),
    .rst_ni     (reset_n),
    .clr_i      (crc_clr),
    .load_i     (1'b0),
    .load_val_i (16'h0000),
    .en_i       (crc_en),
    .bits_i     (sh_q[SDC_WORD_W-1 -: 2]),
    .crc_o      (crc_val)
  );

  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign wrd_cnt   = wrd_cnt_q;
  assign blk_done  = (state_q == ST_CHECK);
  assign crc_ok    = ok_q;
  assign crc_err   = err_q;
  assign len_err   = len_q;
  assign ovr_err   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_sdc_rd_blk_wr_chk.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_sdc_rd_blk_wr_chk : directed vector bench for sdc_rd_blk_wr_chk
// Rev 1.0
// ----------------------------------------------------------------
module tb_sdc_rd_blk_wr_chk;

  localparam int ADDR_W = 9;

  logic              sdc_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] blk_base_addr = '0;
  logic              blk_abort = 1'b0;
  logic              latch_wrd_strb = 1'b0;
  logic [63:0]       dat_wrd = '0;
  logic              latch_crc_strb = 1'b0;
  logic [15:0]       crc_16 = '0;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [63:0]       bram_din;
  logic [6:0]        wrd_cnt;
  logic              blk_done, crc_ok, crc_err, len_err, ovr_err;

  sdc_rd_blk_wr_chk #(.ADDR_W(ADDR_W)) dut (
    .sdc_clk        (sdc_clk),
    .reset_n        (reset_n),
    .blk_base_addr  (blk_base_addr),
    .blk_abort      (blk_abort),
    .latch_wrd_strb (latch_wrd_strb),
    .dat_wrd        (dat_wrd),
    .latch_crc_strb (latch_crc_strb),
    .crc_16         (crc_16),
    .bram_we        (bram_we),
    .bram_addr      (bram_addr),
    .bram_din       (bram_din),
    .wrd_cnt        (wrd_cnt),
    .blk_done       (blk_done),
    .crc_ok         (crc_ok),
    .crc_err        (crc_err),
    .len_err        (len_err),
    .ovr_err        (ovr_err)
  );

  always #5 sdc_clk = ~sdc_clk;

  typedef struct {
    logic [63:0] dat;
    logic [8:0]  base;
    int          nwords;
    int          spacing;
    logic [15:0] crc;
    int          crc_dly;
    logic        e_ok, e_err, e_len, e_ovr;
  } vec_t;

  vec_t vecs[5];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;

  always @(posedge sdc_clk) cyc <= cyc + 1;
  always @(negedge sdc_clk) if (blk_done === 1'b1) begin
    done_cnt <= done_cnt + 1;
    done_cyc <= cyc;
  end

  task automatic tick();
    @(negedge sdc_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_block(input vec_t v, input int k);
    int         start_done, w, c, eng_end, exp_done;
    logic [8:0] a;
    start_done = done_cnt;
    eng_end    = -1000;
    blk_base_addr = v.base;
    for (int i = 0; i < v.nwords; i++) begin
      dat_wrd = v.dat;
      latch_wrd_strb = 1'b1;
      tick();
      latch_wrd_strb = 1'b0;
      w = cyc;
      if (w > eng_end) eng_end = w + 32;
      a = v.base + 9'(i);
      check($sformatf("v%0d w%0d we", k, i), 64'(bram_we), 64'd1);
      check($sformatf("v%0d w%0d addr", k, i), 64'(bram_addr), 64'(a));
      check($sformatf("v%0d w%0d din", k, i), bram_din, v.dat);
      check($sformatf("v%0d w%0d cnt", k, i), 64'(wrd_cnt), 64'(i + 1));
      if (i == 0)
        check($sformatf("v%0d flags_clr", k), 64'({crc_ok, crc_err, len_err}), 64'd0);
      if (i < v.nwords - 1)
        for (int s = 1; s < v.spacing; s++) begin
          tick();
          if (s == 1) check($sformatf("v%0d w%0d we_pulse", k, i), 64'(bram_we), 64'd0);
        end
    end
    repeat (v.crc_dly) tick();
    crc_16 = v.crc;
    latch_crc_strb = 1'b1;
    tick();
    latch_crc_strb = 1'b0;
    c = cyc;
    exp_done = (eng_end + 1 > c) ? eng_end + 1 : c;
    for (int t = 0; t < 100 && done_cnt == start_done; t++) tick();
    check($sformatf("v%0d done_cyc", k), 64'(done_cyc), 64'(exp_done));
    check($sformatf("v%0d crc_ok", k), 64'(crc_ok), 64'(v.e_ok));
    check($sformatf("v%0d crc_err", k), 64'(crc_err), 64'(v.e_err));
    check($sformatf("v%0d len_err", k), 64'(len_err), 64'(v.e_len));
    check($sformatf("v%0d ovr_err", k), 64'(ovr_err), 64'(v.e_ovr));
    repeat (3) tick();
    check($sformatf("v%0d done_pulses", k), 64'(done_cnt - start_done), 64'd1);
    check($sformatf("v%0d sticky_ok", k), 64'(crc_ok), 64'(v.e_ok));
  endtask

  initial begin
    int d0;
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 9'h000, 64, 64, 16'h7FA1, 40, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 9'h000, 64, 64, 16'h7FA0, 2,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{64'h0000_0000_0000_0000, 9'h1F0, 64, 64, 16'h0000, 40, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 9'h000, 63, 64, 16'h7FA1, 0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 9'h040, 2,  10, 16'h0000, 40, 1'b0, 1'b1, 1'b1, 1'b1};

    repeat (3) tick();
    check("reset_din", bram_din, 64'd0);
    check("reset_outs", 64'({bram_we, bram_addr, wrd_cnt, blk_done, crc_ok, crc_err, len_err, ovr_err}), 64'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Abort mid-block: flags and count clear, later CRC strobe ignored.
    d0 = done_cnt;
    blk_base_addr = 9'h100;
    dat_wrd = 64'hA5A5_A5A5_A5A5_A5A5;
    latch_wrd_strb = 1'b1; tick(); latch_wrd_strb = 1'b0;
    repeat (9) tick();
    latch_wrd_strb = 1'b1; tick(); latch_wrd_strb = 1'b0;
    check("abort ovr_set", 64'(ovr_err), 64'd1);
    repeat (3) tick();
    blk_abort = 1'b1; tick(); blk_abort = 1'b0;
    check("abort flags", 64'({crc_ok, crc_err, len_err, ovr_err}), 64'd0);
    check("abort cnt", 64'(wrd_cnt), 64'd0);
    latch_crc_strb = 1'b1; tick(); latch_crc_strb = 1'b0;
    repeat (50) tick();
    check("abort no_done", 64'(done_cnt - d0), 64'd0);

    for (int k = 0; k < 5; k++) run_block(vecs[k], k);

    // Reset in the middle of a block, then a clean block.
    d0 = done_cnt;
    blk_base_addr = 9'h000;
    dat_wrd = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      latch_wrd_strb = 1'b1; tick(); latch_wrd_strb = 1'b0;
      repeat (63) tick();
    end
    check("rst pre_cnt", 64'(wrd_cnt), 64'd30);
    reset_n = 1'b0;
    tick();
    check("rst outs", 64'({bram_we, wrd_cnt, blk_done, crc_ok, crc_err, len_err, ovr_err}), 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (60) tick();
    check("rst no_done", 64'(done_cnt - d0), 64'd0);
    run_block(vecs[0], 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdc_rd_blk_wr_chk.md
Name: sdc_rd_blk_wr_chk

Overview:
- Downstream consumer of the single-block read deserialiser. Takes each 64-bit data word (latch_wrd_strb/dat_wrd) and writes it into the data BRAM at an incrementing address.
- In parallel, recomputes the SD CRC-16 (CCITT, poly 0x1021, init 0) over the block. On the CRC strobe it compares the result against the received crc_16 and reports block done with pass/fail status to the ADMA2 side.

Parameters:
- ADDR_W, 9, BRAM word-address width.
- WORDS_PER_BLK, 64, 64-bit words per block (512 bytes).
- CRC_POLY, 16'h1021, CRC-16 generator polynomial.

Ports:
- sdc_clk  in  1  SD card clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- blk_base_addr  in  ADDR_W  BRAM word address of word 0 of the block; sampled on the first word strobe.
- blk_abort  in  1  synchronous clear to IDLE; no status pulse.
- latch_wrd_strb  in  1  1-cycle strobe, dat_wrd valid.
- dat_wrd  in  64  data word; bit 63 is the first bit received on DAT0.
- latch_crc_strb  in  1  1-cycle strobe, crc_16 valid.
- crc_16  in  16  received CRC.
- bram_we  out  1  BRAM write enable, 1-cycle pulse.
- bram_addr  out  ADDR_W  BRAM write address.
- bram_din  out  64  BRAM write data.
- wrd_cnt  out  7  words accepted in the current block.
- blk_done  out  1  1-cycle pulse, block verdict available.
- crc_ok  out  1  sticky pass flag.
- crc_err  out  1  sticky fail flag.
- len_err  out  1  sticky flag: word count at CRC strobe ≠ WORDS_PER_BLK.
- ovr_err  out  1  sticky flag: word strobe arrived while the CRC engine was busy.

Behaviour:
- Reset values: all outputs 0, state IDLE, CRC register 0. Reset asserted mid-block aborts immediately; no blk_done is produced.
- BRAM path (independent of the FSM):
  - On latch_wrd_strb, the next cycle drives bram_we=1, bram_din=dat_wrd, bram_addr=base_q+wrd_cnt (pre-increment value).
  - wrd_cnt increments in that same cycle and saturates at 127.
  - Address arithmetic wraps modulo 2^ADDR_W.
- CRC engine:
  - Processes 2 bits/cycle, MSB first. Per bit: fb=crc[15]^bit; crc={crc[14:0],0}^(fb?CRC_POLY:0).
  - A word takes 32 cycles, measured from the cycle after its strobe.
  - busy is asserted during those 32 cycles.
- FSM states:
  - IDLE:
    - On latch_wrd_strb: capture blk_base_addr into base_q, clear wrd_cnt/crc/all sticky flags, load the word into the shift register, go to SHIFT.
    - latch_crc_strb in IDLE is ignored.
  - SHIFT: 32 cycles, then go to WAIT.
    - latch_wrd_strb while busy sets ovr_err. That word is still written to BRAM and counted, but is excluded from the CRC.
    - latch_crc_strb while busy captures crc_16 into crc_exp and sets a pending flag.
  - WAIT:
    - latch_wrd_strb: load the word, go to SHIFT.
    - latch_crc_strb (or pending flag set on entry): capture crc_exp, go to CHECK.
  - CHECK (1 cycle), then go to IDLE:
    - blk_done=1.
    - crc_ok=(crc==crc_exp)&&!len_err&&!ovr_err.
    - crc_err=!crc_ok.
    - len_err=(wrd_cnt≠WORDS_PER_BLK).
- Simultaneous events:
  - Word strobe and CRC strobe in the same cycle: the word is processed first, and the CRC is marked pending.
  - blk_abort has priority over all strobes.
- Sticky flags hold until the next block's first word strobe, blk_abort, or reset.
- Latency: last word strobe to blk_done = 34 cycles minimum, or 1 cycle after the CRC strobe if the engine is already idle.

Decomposition:
- Shared package sdc_pkg: CRC16_POLY, SDC_WORDS_PER_BLK, SDC_WORD_W=64, FSM state encoding (one-hot localparams).
- One natural sub-module, sdc_crc16_ser2: a 2-bit-per-cycle CRC-16 step with load/clear/enable. It is reusable for the write path.

Test Plan:
- 64 words of 64'hFFFF_FFFF_FFFF_FFFF at 64-cycle spacing, base 0x000, then crc_16=16'h7FA1 → bram_addr 0..63 written in order, blk_done pulse, crc_ok=1, crc_err=0.
- Same block with crc_16=16'h7FA0 → crc_err=1, crc_ok=0, len_err=0.
- 64 words of zero, base 0x1F0, crc_16=0 → crc_ok=1; bram_addr wraps 0x1F0..0x1FF then 0x000..0x02F.
- Only 63 words then CRC strobe → len_err=1, crc_err=1, blk_done pulses once.
- Second word strobe 10 cycles after the first → ovr_err=1, both words written to BRAM, final crc_err=1.
- reset_n asserted at word 30, then a clean 64-word 0xFF block → no blk_done for the aborted block, wrd_cnt restarts at 0, second block crc_ok=1.
